// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared definitions for the data-memory arbiter.
//   arb_state_t : arbiter FSM state encoding (IDLE / owned by m0 / owned by m1)
//   M_CPU/M_DMA : requester indices, also used as the round-robin priority value
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } arb_state_t;

    localparam logic M_CPU = 1'b0;
    localparam logic M_DMA = 1'b1;

endpackage

// File: rtl/dmem_arb_resp.sv
// dmem_arb_resp: registered response stage for one requester.
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   gnt, we, mis    : this requester was granted, transaction is a write,
//                     transaction is misaligned (always 0 without alignment check)
//   rd              : combinational memory read data
//   rvalid, rdata   : one-cycle read-valid pulse and read data held until next read
//   err             : one-cycle misalignment error pulse
// Optional feature macro: DMEM_ARB_ALIGN_CHK_EN (drives mis in the top level).
module dmem_arb_resp
    import dmem_arb_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          gnt,
    input  logic          we,
    input  logic          mis,
    input  logic [DW-1:0] rd,
    output logic          rvalid,
    output logic [DW-1:0] rdata,
    output logic          err
);

    logic          rd_take;
    logic          vld_p1;
    logic [DW-1:0] rdata_p1;
    logic          err_p1;

    assign rd_take = gnt & ~we & ~mis;

    // grant edge -> response cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1   <= 1'b0;
            err_p1   <= 1'b0;
            rdata_p1 <= '0;
        end else begin
            vld_p1 <= rd_take;
            err_p1 <= gnt & mis;
            if (rd_take) begin
                rdata_p1 <= rd;
            end
        end
    end

    assign rvalid = vld_p1;
    assign rdata  = rdata_p1;
    assign err    = err_p1;

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares a single-port data memory between the CPU load/store
// path (m0) and a DMA/debug loader (m1). Round-robin between requesters, with
// an optional lock that keeps ownership for up to LOCK_MAX consecutive grants.
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   mX_req/we/lock/addr/wdata  : requester X transaction, held until mX_gnt
//   mX_gnt                     : combinational accept
//   mX_rvalid/rdata            : registered read response, 1-cycle latency
//   mX_err                     : misalignment error pulse (0 unless enabled)
//   mem_we/mem_a/mem_wd/mem_rd : data memory interface
// Optional feature macro: DMEM_ARB_ALIGN_CHK_EN -- when defined, accesses with
// addr[1:0] != 0 are granted but suppressed and flagged on mX_err; when
// undefined, address bits [1:0] are ignored.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int LOCK_MAX = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic          m0_lock,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic          m1_lock,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m0_gnt,
    output logic          m1_gnt,
    output logic          m0_rvalid,
    output logic          m1_rvalid,
    output logic [DW-1:0] m0_rdata,
    output logic [DW-1:0] m1_rdata,
    output logic          m0_err,
    output logic          m1_err,
    output logic          mem_we,
    output logic [AW-1:0] mem_a,
    output logic [DW-1:0] mem_wd,
    input  logic [DW-1:0] mem_rd
);

    localparam logic [7:0] LOCK_MAX_C = 8'(LOCK_MAX);

    arb_state_t    state;
    logic          prio;
    logic [7:0]    lock_cnt;
    logic          gnt0;
    logic          gnt1;
    logic          mis0;
    logic          mis1;
    logic [AW-1:0] sel_addr;

`ifdef DMEM_ARB_ALIGN_CHK_EN
    assign mis0  = (m0_addr[1:0] != 2'b00);
    assign mis1  = (m1_addr[1:0] != 2'b00);
    assign mem_a = sel_addr;
`else
    localparam logic [AW-1:0] ADDR_MASK = ~AW'(3);
    assign mis0  = 1'b0;
    assign mis1  = 1'b0;
    assign mem_a = sel_addr & ADDR_MASK;
`endif

    // An owner excludes the other requester; in IDLE a tie goes to prio.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        case (state)
            ST_IDLE: begin
                if (m0_req && m1_req) begin
                    gnt0 = (prio == M_CPU);
                    gnt1 = (prio == M_DMA);
                end else begin
                    gnt0 = m0_req;
                    gnt1 = m1_req;
                end
            end
            ST_OWN0: gnt0 = m0_req;
            ST_OWN1: gnt1 = m1_req;
            default: begin
                gnt0 = 1'b0;
                gnt1 = 1'b0;
            end
        endcase
    end

    assign m0_gnt   = gnt0;
    assign m1_gnt   = gnt1;
    // With no grant the memory sees m0's address and no write.
    assign sel_addr = gnt1 ? m1_addr : m0_addr;
    assign mem_wd   = gnt1 ? m1_wdata : m0_wdata;
    assign mem_we   = (gnt0 & m0_we & ~mis0) | (gnt1 & m1_we & ~mis1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            prio     <= M_CPU;
            lock_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // Priority rotates only when there was a real contest.
                    if (m0_req && m1_req) begin
                        prio <= gnt0 ? M_DMA : M_CPU;
                    end
                    if (gnt0 && m0_lock) begin
                        state    <= ST_OWN0;
                        lock_cnt <= 8'd1;
                    end else if (gnt1 && m1_lock) begin
                        state    <= ST_OWN1;
                        lock_cnt <= 8'd1;
                    end
                end
                ST_OWN0: begin
                    if (gnt0 && m0_lock && (lock_cnt < LOCK_MAX_C)) begin
                        lock_cnt <= lock_cnt + 8'd1;
                    end else begin
                        state    <= ST_IDLE;
                        prio     <= M_DMA;
                        lock_cnt <= '0;
                    end
                end
                ST_OWN1: begin
                    if (gnt1 && m1_lock && (lock_cnt < LOCK_MAX_C)) begin
                        lock_cnt <= lock_cnt + 8'd1;
                    end else begin
                        state    <= ST_IDLE;
                        prio     <= M_CPU;
                        lock_cnt <= '0;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    lock_cnt <= '0;
                end
            endcase
        end
    end

    dmem_arb_resp #(.DW(DW)) u_resp0 (
        .clk    (clk),
        .reset  (reset),
        .gnt    (gnt0),
        .we     (m0_we),
        .mis    (mis0),
        .rd     (mem_rd),
        .rvalid (m0_rvalid),
        .rdata  (m0_rdata),
        .err    (m0_err)
    );

    dmem_arb_resp #(.DW(DW)) u_resp1 (
        .clk    (clk),
        .reset  (reset),
        .gnt    (gnt1),
        .we     (m1_we),
        .mis    (mis1),
        .rd     (mem_rd),
        .rvalid (m1_rvalid),
        .rdata  (m1_rdata),
        .err    (m1_err)
    );

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

    localparam int LMAX = 3;

    logic        clk;
    logic        reset;
    logic        init_en;
    logic        m0_req, m0_we, m0_lock;
    logic [31:0] m0_addr, m0_wdata;
    logic        m1_req, m1_we, m1_lock;
    logic [31:0] m1_addr, m1_wdata;
    logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic        mem_we;
    logic [31:0] mem_a, mem_wd, mem_rd;

    logic [31:0] mem [64];

    int n_vec = 0;
    int n_err = 0;

    dmem_arbiter #(.AW(32), .DW(32), .LOCK_MAX(LMAX)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m0_gnt(m0_gnt), .m1_gnt(m1_gnt),
        .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
        .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
        .m0_err(m0_err), .m1_err(m1_err),
        .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory: combinational read, write on the rising edge.
    assign mem_rd = mem[mem_a[7:2]];
    always @(posedge clk) begin
        if (init_en) begin
            for (int i = 0; i < 64; i++)
                mem[i] <= (i == 1) ? 32'h1234_5678 : (32'hA000_0000 + 32'(i));
        end else if (mem_we) begin
            mem[mem_a[7:2]] <= mem_wd;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit r0, input bit w0, input bit l0, input logic [31:0] a0,
                         input logic [31:0] d0, input bit r1, input bit w1, input bit l1,
                         input logic [31:0] a1, input logic [31:0] d1);
        m0_req = r0; m0_we = w0; m0_lock = l0; m0_addr = a0; m0_wdata = d0;
        m1_req = r1; m1_we = w1; m1_lock = l1; m1_addr = a1; m1_wdata = d1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        bit          r0, w0, l0;
        logic [31:0] a0, d0;
        bit          r1, w1, l1;
        logic [31:0] a1, d1;
        bit          eg0, eg1, ewe;
        bit          erv0;
        logic [31:0] erd0;
        bit          erv1;
        logic [31:0] erd1;
    } vec_t;

    function automatic vec_t mk(bit r0, bit w0, bit l0, logic [31:0] a0, logic [31:0] d0,
                                bit r1, bit w1, bit l1, logic [31:0] a1, logic [31:0] d1,
                                bit eg0, bit eg1, bit ewe,
                                bit erv0, logic [31:0] erd0, bit erv1, logic [31:0] erd1);
        vec_t v;
        v.r0 = r0; v.w0 = w0; v.l0 = l0; v.a0 = a0; v.d0 = d0;
        v.r1 = r1; v.w1 = w1; v.l1 = l1; v.a1 = a1; v.d1 = d1;
        v.eg0 = eg0; v.eg1 = eg1; v.ewe = ewe;
        v.erv0 = erv0; v.erd0 = erd0; v.erv1 = erv1; v.erd1 = erd1;
        return v;
    endfunction

    vec_t tbl[20];

    // random-phase model state
    logic [31:0] smem [64];
    bit          pend[2], pw[2], pl[2];
    logic [31:0] pa[2], pd[2];
    bit          erv[2], nrv[2];
    logic [31:0] erd[2];
    int          owner, prio_m, cnt_m, g, w;

    initial begin
        //              m0: r w l addr         data           m1: r w l addr   data          g0 g1 we  rv0 rd0           rv1 rd1
        tbl[0]  = mk(1,0,0,32'h04,0,            0,0,0,32'h00,0,            1,0,0, 0,0,            0,0);
        tbl[1]  = mk(0,0,0,32'h00,0,            0,0,0,32'h00,0,            0,0,0, 1,32'h12345678, 0,0);
        tbl[2]  = mk(1,0,0,32'h00,0,            1,0,0,32'h08,0,            1,0,0, 0,0,            0,0);
        tbl[3]  = mk(1,0,0,32'h00,0,            1,0,0,32'h08,0,            0,1,0, 1,32'hA0000000, 0,0);
        tbl[4]  = mk(1,0,0,32'h00,0,            1,0,0,32'h08,0,            1,0,0, 0,0,            1,32'hA0000002);
        tbl[5]  = mk(1,0,0,32'h00,0,            1,0,0,32'h08,0,            0,1,0, 1,32'hA0000000, 0,0);
        tbl[6]  = mk(0,0,0,32'h00,0,            0,0,0,32'h00,0,            0,0,0, 0,0,            1,32'hA0000002);
        tbl[7]  = mk(0,0,0,32'h00,0,            1,1,0,32'h10,32'hDEADBEEF, 0,1,1, 0,0,            0,0);
        tbl[8]  = mk(1,0,0,32'h10,0,            0,0,0,32'h00,0,            1,0,0, 0,0,            0,0);
        tbl[9]  = mk(0,0,0,32'h00,0,            0,0,0,32'h00,0,            0,0,0, 1,32'hDEADBEEF, 0,0);
        tbl[10] = mk(1,0,1,32'h00,0,            1,0,0,32'h08,0,            1,0,0, 0,0,            0,0);
        tbl[11] = mk(1,0,1,32'h00,0,            1,0,0,32'h08,0,            1,0,0, 1,32'hA0000000, 0,0);
        tbl[12] = mk(1,0,1,32'h00,0,            1,0,0,32'h08,0,            1,0,0, 1,32'hA0000000, 0,0);
        tbl[13] = mk(1,0,1,32'h00,0,            1,0,0,32'h08,0,            1,0,0, 1,32'hA0000000, 0,0);
        tbl[14] = mk(1,0,1,32'h00,0,            1,0,0,32'h08,0,            0,1,0, 1,32'hA0000000, 0,0);
        tbl[15] = mk(0,0,0,32'h00,0,            0,0,0,32'h00,0,            0,0,0, 0,0,            1,32'hA0000002);
        tbl[16] = mk(1,0,1,32'h04,0,            0,0,0,32'h00,0,            1,0,0, 0,0,            0,0);
        tbl[17] = mk(0,0,0,32'h00,0,            1,0,0,32'h08,0,            0,0,0, 1,32'h12345678, 0,0);
        tbl[18] = mk(0,0,0,32'h00,0,            1,0,0,32'h08,0,            0,1,0, 0,0,            0,0);
        tbl[19] = mk(0,0,0,32'h00,0,            0,0,0,32'h00,0,            0,0,0, 0,0,            1,32'hA0000002);

        // reset and memory preload
        drive(0,0,0,0,0, 0,0,0,0,0);
        init_en = 1'b1;
        reset   = 1'b1;
        next_cycle();
        next_cycle();
        init_en = 1'b0;
        reset   = 1'b0;
        @(negedge clk);
        chk("reset_rvalid0", 32'(m0_rvalid), 0);
        chk("reset_rvalid1", 32'(m1_rvalid), 0);
        chk("reset_rdata0", m0_rdata, 0);
        chk("reset_rdata1", m1_rdata, 0);
        chk("reset_err0", 32'(m0_err), 0);
        chk("reset_err1", 32'(m1_err), 0);
        next_cycle();

        // directed table
        for (int i = 0; i < 20; i++) begin
            drive(tbl[i].r0, tbl[i].w0, tbl[i].l0, tbl[i].a0, tbl[i].d0,
                  tbl[i].r1, tbl[i].w1, tbl[i].l1, tbl[i].a1, tbl[i].d1);
            @(negedge clk);
            chk($sformatf("tbl%0d_gnt0", i), 32'(m0_gnt), 32'(tbl[i].eg0));
            chk($sformatf("tbl%0d_gnt1", i), 32'(m1_gnt), 32'(tbl[i].eg1));
            chk($sformatf("tbl%0d_mem_we", i), 32'(mem_we), 32'(tbl[i].ewe));
            chk($sformatf("tbl%0d_rvalid0", i), 32'(m0_rvalid), 32'(tbl[i].erv0));
            chk($sformatf("tbl%0d_rvalid1", i), 32'(m1_rvalid), 32'(tbl[i].erv1));
            if (tbl[i].erv0) chk($sformatf("tbl%0d_rdata0", i), m0_rdata, tbl[i].erd0);
            if (tbl[i].erv1) chk($sformatf("tbl%0d_rdata1", i), m1_rdata, tbl[i].erd1);
            next_cycle();
        end

        // reset while m1 owns the memory and has a read granted
        drive(0,0,0,0,0, 1,0,1,32'h08,0);
        @(negedge clk);
        chk("own1_enter_gnt1", 32'(m1_gnt), 1);
        next_cycle();
        drive(1,0,0,32'h00,0, 1,0,1,32'h0C,0);
        reset = 1'b1;
        @(negedge clk);
        chk("own1_gnt1", 32'(m1_gnt), 1);
        chk("own1_m0_waits", 32'(m0_gnt), 0);
        next_cycle();
        reset = 1'b0;
        drive(1,0,0,32'h00,0, 1,0,0,32'h08,0);
        @(negedge clk);
        chk("rst_own1_rvalid1", 32'(m1_rvalid), 0);
        chk("rst_own1_rdata1", m1_rdata, 0);
        chk("rst_idle_prio0_gnt0", 32'(m0_gnt), 1);
        chk("rst_idle_prio0_gnt1", 32'(m1_gnt), 0);
        next_cycle();

        // misaligned write of 0x1 to 0x06
        drive(1,1,0,32'h06,32'h1, 0,0,0,0,0);
        @(negedge clk);
        chk("mis_gnt0", 32'(m0_gnt), 1);
`ifdef DMEM_ARB_ALIGN_CHK_EN
        chk("mis_mem_we", 32'(mem_we), 0);
`else
        chk("mis_mem_we", 32'(mem_we), 1);
`endif
        next_cycle();
        drive(0,0,0,0,0, 0,0,0,0,0);
        @(negedge clk);
`ifdef DMEM_ARB_ALIGN_CHK_EN
        chk("mis_err0", 32'(m0_err), 1);
        chk("mis_mem_word1", mem[1], 32'h1234_5678);
`else
        chk("mis_err0", 32'(m0_err), 0);
        chk("mis_mem_word1", mem[1], 32'h1);
`endif
        chk("mis_rvalid0", 32'(m0_rvalid), 0);
        next_cycle();

        // randomized traffic against the reference model
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        for (int i = 0; i < 64; i++) smem[i] = mem[i];
        owner = -1; prio_m = 0; cnt_m = 0;
        for (int i = 0; i < 2; i++) begin
            pend[i] = 0; pw[i] = 0; pl[i] = 0; pa[i] = 0; pd[i] = 0;
            erv[i] = 0; erd[i] = 0;
        end
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (!pend[i] && ($urandom_range(0, 99) < 55)) begin
                    pend[i] = 1;
                    pw[i]   = ($urandom_range(0, 99) < 40);
                    pl[i]   = ($urandom_range(0, 99) < 35);
                    pa[i]   = ($urandom & 32'hFFFF_FF00) | (32'($urandom_range(0, 63)) << 2);
                    pd[i]   = $urandom;
                end
            end
            drive(pend[0], pw[0], pl[0], pa[0], pd[0], pend[1], pw[1], pl[1], pa[1], pd[1]);

            if (owner < 0) begin
                if (pend[0] && pend[1]) g = prio_m;
                else if (pend[0])       g = 0;
                else if (pend[1])       g = 1;
                else                    g = -1;
            end else begin
                g = pend[owner] ? owner : -1;
            end

            @(negedge clk);
            chk("rnd_gnt0", 32'(m0_gnt), 32'(g == 0));
            chk("rnd_gnt1", 32'(m1_gnt), 32'(g == 1));
            chk("rnd_mem_we", 32'(mem_we), 32'(g >= 0 && pw[g]));
            if (g >= 0) chk("rnd_mem_word", 32'(mem_a[7:2]), (pa[g] >> 2) & 32'h3F);
            chk("rnd_rvalid0", 32'(m0_rvalid), 32'(erv[0]));
            chk("rnd_rvalid1", 32'(m1_rvalid), 32'(erv[1]));
            if (erv[0]) chk("rnd_rdata0", m0_rdata, erd[0]);
            if (erv[1]) chk("rnd_rdata1", m1_rdata, erd[1]);
            chk("rnd_err", 32'({m1_err, m0_err}), 0);

            nrv[0] = 0; nrv[1] = 0;
            if (g >= 0) begin
                w = int'((pa[g] >> 2) & 32'h3F);
                if (pw[g]) smem[w] = pd[g];
                else begin
                    nrv[g] = 1;
                    erd[g] = smem[w];
                end
            end
            if (owner < 0) begin
                if (pend[0] && pend[1]) prio_m = 1 - g;
                if (g >= 0 && pl[g]) begin
                    owner = g;
                    cnt_m = 1;
                end
            end else begin
                if (g == owner && pl[g] && cnt_m < LMAX) cnt_m++;
                else begin
                    prio_m = 1 - owner;
                    owner  = -1;
                    cnt_m  = 0;
                end
            end
            if (g >= 0) pend[g] = 0;
            erv[0] = nrv[0];
            erv[1] = nrv[1];
            next_cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory (combinational read, write on posedge clk when we) between two requesters.
- Requester m0 is the CPU load/store path; requester m1 is a DMA/debug loader.
- Round-robin arbitration with an optional per-requester lock, so a read-modify-write sequence can run uninterrupted, and a bounded lock length.
- Sits between the requesters and the data memory instance; drives the memory's we, a and wd, and consumes its rd.

Parameters:
- AW, 32, address width (byte address; the memory uses word address a[7:2]).
- DW, 32, data width.
- LOCK_MAX, 8, maximum consecutive grants to a locking owner before forced release (legal range 1..255).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- m0_req, m1_req  input  1  request; address, data, we and lock are held stable until gnt.
- m0_we, m1_we  input  1  1 = write, 0 = read.
- m0_lock, m1_lock  input  1  retain ownership after this transaction.
- m0_addr, m1_addr  input  AW  byte address.
- m0_wdata, m1_wdata  input  DW  write data.
- m0_gnt, m1_gnt  output  1  transaction accepted this cycle (combinational).
- m0_rvalid, m1_rvalid  output  1  read data valid (registered pulse).
- m0_rdata, m1_rdata  output  DW  read data (registered).
- m0_err, m1_err  output  1  misalignment error pulse (see Optional Feature).
- mem_we  output  1  memory write enable.
- mem_a  output  AW  memory address.
- mem_wd  output  DW  memory write data.
- mem_rd  input  DW  memory read data (combinational).

Behaviour:
- Reset is synchronous active-high. On reset:
  - state = IDLE, prio = 0, lock_cnt = 0.
  - All rvalid/err = 0, all rdata = 0.
  - Reset asserted mid-lock or mid-read drops the ownership and any pending rvalid.
- FSM states: IDLE, OWN0, OWN1.
- IDLE:
  - Only one requester active: grant that one.
  - Both active: grant m[prio]; prio <= the other requester at the clock edge.
  - No requests: no grant, mem_we = 0, mem_a = m0_addr.
- OWNx:
  - Only mx may be granted. A request from the other requester waits, with gnt = 0.
- Transitions:
  - IDLE -> OWNx: mx granted with mx_lock = 1; lock_cnt <= 1.
  - Stay in OWNx: mx granted with mx_lock = 1 and lock_cnt < LOCK_MAX; lock_cnt increments.
  - OWNx -> IDLE, any one of:
    - mx granted with lock = 0;
    - mx_req = 0 in that cycle;
    - mx granted with lock_cnt == LOCK_MAX (forced release).
  - On every exit from OWNx: prio <= other requester, lock_cnt <= 0.
- Datapath (combinational from the granted requester):
  - mem_a = addr, mem_wd = wdata, mem_we = gnt & we.
  - A write commits at the same edge as the grant.
- Read latency is 1 cycle:
  - At the grant edge, mx_rdata <= mem_rd.
  - mx_rvalid = 1 in the following cycle for exactly one cycle.
  - rdata holds its value until the next read by the same requester.
- Writes produce no rvalid.
- Back-to-back grants to the same requester sustain 1 transaction per cycle.
- Exactly one gnt is high at most in any cycle.

Optional Feature:
- Macro: DMEM_ARB_ALIGN_CHK_EN.
- Defined:
  - A granted transaction with addr[1:0] != 0 is still granted and consumes its slot, but mem_we is forced to 0.
  - A read produces no rvalid.
  - mx_err pulses 1 in the cycle after the grant.
  - The lock/FSM updates as for a normal transaction.
- Undefined:
  - m0_err = m1_err = 0 constantly.
  - Address bits [1:0] are ignored, so the access is word aligned.

Decomposition:
- Shared package dmem_arb_pkg:
  - State encoding constants: ST_IDLE = 2'd0, ST_OWN0 = 2'd1, ST_OWN1 = 2'd2.
  - Requester index constants M_CPU = 0, M_DMA = 1.
- One natural sub-module: dmem_arb_resp, instantiated once per requester. It holds the registered rdata/rvalid/err response stage.
- FSM and priority logic stay in dmem_arbiter.

Test Plan:
- Reset, then m0 read at addr 0x04 with memory word 1 = 0x12345678 -> m0_gnt high the same cycle; next cycle m0_rvalid = 1, m0_rdata = 0x12345678; m1_rvalid stays 0.
- Both requesters read continuously (m0 addr 0x00, m1 addr 0x08) for 4 cycles after reset -> grants alternate m0, m1, m0, m1; each rvalid trails its grant by 1 cycle.
- m1 writes 0xDEADBEEF to 0x10 while m0 is idle, then m0 reads 0x10 -> mem_we = 1 only in the m1 grant cycle; m0_rdata = 0xDEADBEEF.
- m0 lock with LOCK_MAX = 3 and m1 requesting throughout -> m0 granted 4 consecutive cycles (IDLE grant plus 3 in OWN0), then forced release; m1 granted next.
- Reset asserted while in OWN1 with an m1 read just granted -> next cycle state = IDLE, m1_rvalid = 0, prio = 0.
- DMEM_ARB_ALIGN_CHK_EN defined, m0 writes 0x1 to addr 0x06 -> m0_gnt = 1, mem_we = 0, m0_err pulses the next cycle, memory unchanged. Undefined: the same stimulus writes word 1 and m0_err stays 0.
